csr_arbiter: RTL and testbench
==============================

CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 7, the CSR address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, the CSR data width.
REQ-003 The block SHALL have parameter WR_HOLD, default 4, the number of cycles write_en_o stays high per write.
REQ-004 The block SHALL have parameter WR_GAP, default 4, the number of cycles write_en_o stays low after each write.
REQ-005 The block SHALL have parameter RD_HOLD, default 2, the number of cycles read_en_o stays high per read.
REQ-006 The block SHALL have port clk_i, input, 1, clock.
REQ-007 The block SHALL have port rst_n, input, 1, reset; rst_n is synchronous and active-low, and clk_i is the clock.
REQ-008 The block SHALL have ports r0_valid_i / r1_valid_i, input, 1 each, requester has a pending access.
REQ-009 The block SHALL have ports r0_we_i / r1_we_i, input, 1 each, 1 = write, 0 = read.
REQ-010 The block SHALL have ports r0_addr_i / r1_addr_i, input, ADDR_WIDTH each, access address.
REQ-011 The block SHALL have ports r0_wdata_i / r1_wdata_i, input, DATA_WIDTH each, write data.
REQ-012 The block SHALL have ports r0_done_o / r1_done_o, output, 1 each, one-cycle completion pulse.
REQ-013 The block SHALL have port rdata_o, output, DATA_WIDTH, read result, valid in the done cycle.
REQ-014 The block SHALL have ports addr_o, write_data_o, write_en_o and read_en_o, outputs, ADDR_WIDTH / DATA_WIDTH / 1 / 1, the CSR port toward the register map.
REQ-015 The block SHALL have port read_data_i, input, DATA_WIDTH, register-map read data.
REQ-016 The block SHALL have port busy_o, output, 1, high whenever the FSM is not IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, WRITE, WGAP, READ and RCAP.
REQ-018 In IDLE with any valid high, the block SHALL grant one requester, latch its we/addr/wdata internally and leave IDLE on the next edge.
REQ-019 Arbitration SHALL be round-robin: when both requests are valid, the grant goes to the requester not granted last; the pointer favours r0 after reset.
REQ-020 A lone valid requester SHALL be granted regardless of the pointer, and the pointer SHALL update to the granted index.
REQ-021 addr_o and write_data_o SHALL drive the latched values, stable from grant until the FSM returns to IDLE.
REQ-022 WRITE: write_en_o SHALL be high for exactly WR_HOLD cycles, then go to WGAP.
REQ-023 The granted done SHALL pulse in the last WRITE cycle.
REQ-024 WGAP: write_en_o SHALL be low for exactly WR_GAP cycles, then return to IDLE; no grant is allowed during WGAP.
REQ-025 READ: read_en_o SHALL be high for exactly RD_HOLD cycles, then go to RCAP.
REQ-026 RCAP: the block SHALL capture read_data_i into rdata_o and pulse the granted done in the same cycle as the capture, then return to IDLE, for one cycle.
REQ-027 write_en_o and read_en_o SHALL never be high in the same cycle.
REQ-028 rdata_o SHALL hold its last captured value until the next RCAP; 8'hFF returned by the map for an out-of-range address SHALL pass through unchanged.
REQ-029 Requesters SHALL hold valid and fields until done; requester inputs SHALL be ignored after grant.
REQ-030 Deasserting valid mid-transaction SHALL NOT abort the transaction, and done SHALL still pulse.
REQ-031 Per-access latency from grant edge to done: write = WR_HOLD cycles, read = RD_HOLD+1 cycles.
REQ-032 Back-to-back throughput: write = WR_HOLD+WR_GAP+1 cycles; read = RD_HOLD+2 cycles.
REQ-033 Done SHALL be held low for non-granted requesters.
REQ-034 The phase counter SHALL be wide enough for max(WR_HOLD, WR_GAP, RD_HOLD) and SHALL reset to 0 on each state entry.

Reset
REQ-035 While rst_n=0 at a clk_i edge, the block SHALL set: state = IDLE, counter = 0, pointer = r0-first.
REQ-036 While rst_n=0 at a clk_i edge, all outputs SHALL be 0, including addr_o, write_data_o, rdata_o, done and busy_o.
REQ-037 Reset mid-transaction SHALL abort the transaction immediately, with write_en_o/read_en_o low on the next cycle and no done.
REQ-038 After reset release, a still-valid requester SHALL be re-arbitrated from IDLE.

Verification
REQ-039 Write scenario: r0 writes addr 3 data 8'hA5 -> write_en_o high 4 cycles, addr_o=3, write_data_o=A5 stable, r0_done 1 pulse in the 4th cycle, busy_o low 5 cycles after the done pulse (4 WGAP cycles).
REQ-040 Read scenario: r1 reads addr 13 with the map model returning 8'h5C -> read_en_o high 2 cycles, r1_done pulses with rdata_o=5C, latency 3 cycles.
REQ-041 Contention scenario: r0 and r1 both valid continuously from reset -> grants alternate r0,r1,r0,r1 and neither starves.
REQ-042 Out-of-range scenario: r0 reads addr 100 with the map returning FF -> rdata_o=8'hFF, done pulses.
REQ-043 Reset scenario: rst_n asserted in the 2nd WRITE cycle -> write_en_o=0 next cycle, no done, FSM returns to IDLE; the re-request completes normally.
REQ-044 Invariant checks, all cycles: write_en_o and read_en_o never high together, and addr_o never changes while busy_o=1.

Source files
------------

// File: rtl/csr_arbiter.sv
// Two-requester round-robin arbiter in front of a single CSR port.
// Writes hold write_en_o for WR_HOLD cycles followed by a WR_GAP quiet gap. Reads hold read_en_o
// for RD_HOLD cycles, then spend one cycle capturing read_data_i.
module csr_arbiter #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WR_HOLD    = 4,
  parameter int unsigned WR_GAP     = 4,
  parameter int unsigned RD_HOLD    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  r0_valid_i,
  input  logic                  r1_valid_i,
  input  logic                  r0_we_i,
  input  logic                  r1_we_i,
  input  logic [ADDR_WIDTH-1:0] r0_addr_i,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [DATA_WIDTH-1:0] r0_wdata_i,
  input  logic [DATA_WIDTH-1:0] r1_wdata_i,
  output logic                  r0_done_o,
  output logic                  r1_done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  write_en_o,
  output logic                  read_en_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  busy_o
);

  localparam int unsigned MaxHold =
      (WR_HOLD > WR_GAP) ? ((WR_HOLD > RD_HOLD) ? WR_HOLD : RD_HOLD)
                         : ((WR_GAP > RD_HOLD) ? WR_GAP : RD_HOLD);
  localparam int unsigned CntW = $clog2(MaxHold + 1);

  localparam logic [CntW-1:0] WrLast  = CntW'(WR_HOLD - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(WR_GAP - 1);
  localparam logic [CntW-1:0] RdLast  = CntW'(RD_HOLD - 1);

  typedef enum logic [2:0] {StIdle, StWrite, StWgap, StRead, StRcap} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;  // pretend r1 won last so r0 takes the first tie
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (r0_valid_i || r1_valid_i) begin
          gnt_d   = (r0_valid_i && r1_valid_i) ? ~last_q : r1_valid_i;
          last_d  = gnt_d;
          we_d    = gnt_d ? r1_we_i    : r0_we_i;
          addr_d  = gnt_d ? r1_addr_i  : r0_addr_i;
          wdata_d = gnt_d ? r1_wdata_i : r0_wdata_i;
          state_d = we_d ? StWrite : StRead;
        end
      end
      StWrite: begin
        if (cnt_q == WrLast) begin
          state_d = StWgap;
          cnt_d   = '0;
        end
      end
      StWgap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StRead: begin
        if (cnt_q == RdLast) begin
          state_d = StRcap;
          cnt_d   = '0;
        end
      end
      StRcap: begin
        rdata_d = read_data_i;
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy_o       = (state_q != StIdle);
    write_en_o   = (state_q == StWrite);
    read_en_o    = (state_q == StRead);
    done         = ((state_q == StWrite) && (cnt_q == WrLast)) || (state_q == StRcap);
    r0_done_o    = done && !gnt_q;
    r1_done_o    = done && gnt_q;
    // Read data is forwarded in the capture cycle so it is valid alongside done.
    rdata_o      = (state_q == StRcap) ? read_data_i : rdata_q;
    addr_o       = addr_q;
    write_data_o = wdata_q;
  end

endmodule

// File: tb/tb_csr_arbiter.sv
// Bench for csr_arbiter: transaction-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_csr_arbiter;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;
  localparam int unsigned WR_HOLD = 4;
  localparam int unsigned WR_GAP  = 4;
  localparam int unsigned RD_HOLD = 2;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          rv  [2];
  logic          rwe [2];
  logic [AW-1:0] ra  [2];
  logic [DW-1:0] rw  [2];
  logic          r0_done_o, r1_done_o, write_en_o, read_en_o, busy_o;
  logic [DW-1:0] rdata_o, write_data_o, read_data_i;
  logic [AW-1:0] addr_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  // Register map: addresses 96 and up are out of range and return FF.
  function automatic logic [DW-1:0] map_rd(input logic [AW-1:0] a);
    if (a >= 7'd96) return 8'hFF;
    if (a == 7'd13) return 8'h5C;
    return (8'(a) * 8'd7) ^ 8'h3C;
  endfunction

  assign read_data_i = map_rd(addr_o);

  csr_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WR_HOLD    (WR_HOLD),
    .WR_GAP     (WR_GAP),
    .RD_HOLD    (RD_HOLD)
  ) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .r0_valid_i   (rv[0]),
    .r1_valid_i   (rv[1]),
    .r0_we_i      (rwe[0]),
    .r1_we_i      (rwe[1]),
    .r0_addr_i    (ra[0]),
    .r1_addr_i    (ra[1]),
    .r0_wdata_i   (rw[0]),
    .r1_wdata_i   (rw[1]),
    .r0_done_o    (r0_done_o),
    .r1_done_o    (r1_done_o),
    .rdata_o      (rdata_o),
    .addr_o       (addr_o),
    .write_data_o (write_data_o),
    .write_en_o   (write_en_o),
    .read_en_o    (read_en_o),
    .read_data_i  (read_data_i),
    .busy_o       (busy_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is a timeline of t = 1.. cycles after the grant edge.
  bit            m_init = 0;
  bit            m_busy = 0;
  int            m_t    = 0;
  bit            m_idx  = 0;
  bit            m_we   = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_fav  = 0;
  bit            exp_done [2] = '{0, 0};
  bit            prev_busy = 0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk_i) begin
    bit e_wen, e_ren, e_done;
    logic [DW-1:0] e_rd;
    int len;
    e_wen  = m_busy && m_we && (m_t <= WR_HOLD);
    e_ren  = m_busy && !m_we && (m_t <= RD_HOLD);
    e_done = m_busy && (m_we ? (m_t == WR_HOLD) : (m_t == RD_HOLD + 1));
    e_rd   = (e_done && !m_we) ? map_rd(m_addr) : m_rdata;
    exp_done[0] = e_done && !m_idx;
    exp_done[1] = e_done && m_idx;
    if (m_init) begin
      chk("busy_o", busy_o, m_busy);
      chk("write_en_o", write_en_o, e_wen);
      chk("read_en_o", read_en_o, e_ren);
      chk("r0_done_o", r0_done_o, exp_done[0]);
      chk("r1_done_o", r1_done_o, exp_done[1]);
      chk("rdata_o", rdata_o, e_rd);
      if (m_busy) begin
        chk("addr_o", addr_o, m_addr);
        if (m_we) chk("write_data_o", write_data_o, m_wdata);
      end
      chk("en_exclusive", write_en_o && read_en_o, 1'b0);
      if (busy_o && prev_busy) chk("addr_stable", addr_o, prev_addr);
    end
    prev_busy = busy_o;
    prev_addr = addr_o;
    if (!rst_n) begin
      m_busy = 0; m_fav = 0; m_rdata = '0; m_init = 1;
    end else if (m_busy) begin
      if (e_done && !m_we) m_rdata = map_rd(m_addr);
      m_t++;
      len = m_we ? WR_HOLD + WR_GAP : RD_HOLD + 1;
      if (m_t > len) m_busy = 0;
    end else if (rv[0] || rv[1]) begin
      m_idx   = (rv[0] && rv[1]) ? m_fav : rv[1];
      m_fav   = ~m_idx;
      m_we    = rwe[m_idx];
      m_addr  = ra[m_idx];
      m_wdata = rw[m_idx];
      m_busy  = 1;
      m_t     = 1;
    end
  end

  // Issue one request and observe the 20 cycles following the grant edge.
  task automatic run_txn(input int r, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int en_cnt, output int done_at,
                         output int busy_last, output logic [DW-1:0] rd);
    @(posedge clk_i); #1;
    rv[r] = 1; rwe[r] = we; ra[r] = a; rw[r] = d;
    en_cnt = 0; done_at = 0; busy_last = 0; rd = '0;
    @(negedge clk_i);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      if (write_en_o || read_en_o) en_cnt++;
      if (busy_o) busy_last = n;
      if ((r == 0) ? r0_done_o : r1_done_o) begin
        done_at = n;
        rd = rdata_o;
        @(posedge clk_i); #1;
        rv[r] = 0;
      end
    end
  endtask

  initial begin
    int en_cnt, done_at, busy_last;
    logic [DW-1:0] rd;
    int seq[$];
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; rwe[i] = 0; ra[i] = '0; rw[i] = '0;
    end

    // Reset with both requesters already asserting reads; then contention.
    rv[0] = 1; ra[0] = 7'd5; rv[1] = 1; ra[1] = 7'd6;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst busy_o", busy_o, 1'b0);
    chk("rst write_en_o", write_en_o, 1'b0);
    chk("rst read_en_o", read_en_o, 1'b0);
    chk("rst r0_done_o", r0_done_o, 1'b0);
    chk("rst r1_done_o", r1_done_o, 1'b0);
    chk("rst addr_o", addr_o, 7'd0);
    chk("rst write_data_o", write_data_o, 8'd0);
    chk("rst rdata_o", rdata_o, 8'd0);
    @(posedge clk_i); #1;
    rst_n = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (r0_done_o) seq.push_back(0);
      if (r1_done_o) seq.push_back(1);
    end
    chk("contention done count", seq.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < seq.size(); i++) chk("contention order", seq[i], i % 2);
    @(posedge clk_i); #1;
    rv[0] = 0; rv[1] = 0;
    repeat (8) @(posedge clk_i);

    run_txn(0, 1'b1, 7'd3, 8'hA5, en_cnt, done_at, busy_last, rd);
    chk("wr en cycles", en_cnt, 4);
    chk("wr done cycle", done_at, 4);
    chk("wr busy last", busy_last, 8);

    run_txn(1, 1'b0, 7'd13, 8'h00, en_cnt, done_at, busy_last, rd);
    chk("rd en cycles", en_cnt, 2);
    chk("rd done cycle", done_at, 3);
    chk("rd data", rd, 8'h5C);
    chk("rd busy last", busy_last, 3);

    run_txn(0, 1'b0, 7'd100, 8'h00, en_cnt, done_at, busy_last, rd);
    chk("oor done cycle", done_at, 3);
    chk("oor data", rd, 8'hFF);

    // Reset during the second WRITE cycle, requester stays valid.
    @(posedge clk_i); #1;
    rv[0] = 1; rwe[0] = 1; ra[0] = 7'd9; rw[0] = 8'h3C;
    @(negedge clk_i);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_n = 0;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_n = 1;
    @(negedge clk_i);
    chk("abort write_en_o", write_en_o, 1'b0);
    chk("abort busy_o", busy_o, 1'b0);
    chk("abort r0_done_o", r0_done_o, 1'b0);
    en_cnt = 0; done_at = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      if (write_en_o) en_cnt++;
      if (r0_done_o) begin
        done_at = n;
        @(posedge clk_i); #1;
        rv[0] = 0;
      end
    end
    chk("rearb done cycle", done_at, 4);
    chk("rearb en cycles", en_cnt, 4);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk_i); #1;
      rst_n = ($urandom_range(399) == 0) ? 1'b0 : 1'b1;
      for (int r = 0; r < 2; r++) begin
        if (rv[r] && exp_done[r]) begin
          rv[r] = 0;
        end else if (!rv[r] && $urandom_range(3) == 0) begin
          rv[r]  = 1;
          rwe[r] = 1'($urandom_range(1));
          ra[r]  = AW'($urandom_range(127));
          rw[r]  = DW'($urandom_range(255));
        end else if (rv[r] && m_busy && (int'(m_idx) == r) && $urandom_range(15) == 0) begin
          rv[r] = 0;
        end
      end
    end
    @(posedge clk_i); #1;
    rst_n = 1; rv[0] = 0; rv[1] = 0;
    repeat (12) @(posedge clk_i);
    @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
